mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported backing memory between the pipeline's instruction-fetch port and data-memory port. It sits between the datapath's fetch and memory stages and the memory, grants one requester at a time with round-robin tie-breaking, and holds the pipeline with a stall signal while either port waits. A watchdog aborts transactions the memory never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width (byte address, passed through unmodified)
- DATA_W, 32, data width
- TIMEOUT, 255, max BUSY cycles without m_ack before abort (≥1, counter width $clog2(TIMEOUT+1))
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out read

Ports:
- ctrl_bus  ctrl_bus_if.central  —  supplies ctrl_bus.clk and ctrl_bus.reset. One clock; reset is synchronous and active-high.
- i_req  in  1  fetch request; held with i_addr stable until i_ready
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched instruction, valid while i_ready
- i_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ready
- d_ready  out  1  one-cycle completion pulse for data
- m_req  out  1  memory request, registered
- m_we  out  1  memory write enable, registered
- m_addr  out  ADDR_W  memory address, registered
- m_wdata  out  DATA_W  memory write data, registered
- m_rdata  in  DATA_W  memory read data, sampled on m_ack
- m_ack  in  1  memory completion, may assert in the first m_req cycle
- stall  out  1  (i_req & ~i_ready) | (d_req & ~d_ready), combinational
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if neither req, stay. If only one req, grant it. If both, grant the port not granted last (last_d register; reset value 1, so fetch wins first after reset). Grant: load m_addr/m_we/m_wdata from the winner (m_we = 0 for fetch), set m_req = 1, set owner, update last_d, clear watchdog, go to BUSY.
- BUSY: m_req and m_* held stable. On m_ack: capture m_rdata into owner's rdata register (loads and fetches only; on a store d_rdata keeps its previous value), drop m_req, go to RESP. Without m_ack the watchdog increments. If it reaches TIMEOUT, abort as if acked, with rdata = ERR_DATA for reads, and set err.
- RESP: owner's ready = 1 for exactly this cycle. Requests are not sampled. Next state is IDLE unconditionally.
- The non-owner port waits with its ready low. Its request is never dropped or reordered.
- m_ack in IDLE or RESP is ignored.
- err clears only on reset.

## Timing
- Reset (synchronous, active-high, effective on the clock edge): state IDLE, m_req/m_we 0, m_addr/m_wdata 0, i_ready/d_ready 0, i_rdata/d_rdata 0, err 0, last_d 1, watchdog 0.
- Reset asserted mid-transaction: at the next edge m_req drops and the transaction is abandoned without a ready pulse. The memory must tolerate the withdrawn request.
- Zero-wait memory (m_ack in first BUSY cycle):
  - req seen cycle 0 (IDLE).
  - m_req = 1 cycle 1.
  - ready = 1 cycle 2.
  - IDLE cycle 3.
  - This gives 2 cycles request-to-ready and a 3-cycle minimum per transaction.
- Each memory wait cycle adds one cycle to the latency.
- Timeout: ready pulses TIMEOUT+1 cycles after m_req rises, err = 1 from that ready cycle onward.
- Requester contract: ready is the cycle in which the pipeline advances. From the cycle after ready, req/address reflect the next access.
- stall is low in the ready cycle when only that port was requesting.

## Test plan
- Single fetch, zero-wait: i_req=1, i_addr=0x0000_0040, m_ack in first m_req cycle with m_rdata=0x2008_0005 -> m_addr=0x40 and m_we=0 at cycle 1; i_ready=1 and i_rdata=0x2008_0005 at cycle 2; stall=1 cycles 0–1.
- Simultaneous requests after reset: i_req and d_req both asserted from cycle 0, zero-wait memory -> fetch served first (i_ready cycle 2), then data (d_ready cycle 5). Repeating both yields an alternating order.
- Store with 3 wait cycles: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xCAFE_F00D -> m_we=1 and m_wdata held stable 4 cycles; d_ready 1 cycle after m_ack; d_rdata unchanged.
- Timeout: TIMEOUT=4, d_req load, m_ack never -> m_req high 5 cycles; d_ready with d_rdata=0xDEAD_BEEF; err=1 and stays 1 across later good transactions.
- Reset mid-BUSY: assert reset during the second wait cycle -> next edge m_req=0, no ready pulse, err=0. After release with i_req held, the first grant goes to fetch.
- Stray ack: m_ack pulsed while in IDLE and in RESP -> no state change, no extra ready, rdata registers unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ctrl_bus_if: clock and reset distribution for mem_arbiter.
//   clk   - single system clock (interface port)
//   reset - synchronous, active-high reset
// Modports:
//   central - consumer side (the arbiter samples clk and reset)
//   source  - producer side (whoever drives reset)
interface ctrl_bus_if (
    input logic clk
);
    logic reset;

    modport central (input clk, input reset);
    modport source  (input clk, output reset);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction-fetch
// port (i_*) and the data port (d_*). One transaction at a time, round-robin
// when both ports request together, and a watchdog that aborts a transaction
// the memory never acknowledges.
//   ctrl_bus            - clock and synchronous active-high reset
//   i_req/i_addr        - fetch request, held until i_ready
//   i_rdata/i_ready     - fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata - data request, held until d_ready
//   d_rdata/d_ready     - load data and one-cycle completion pulse
//   m_req/m_we/m_addr/m_wdata - registered memory request
//   m_rdata/m_ack       - memory response (m_ack may come in the first m_req cycle)
//   stall               - pipeline hold while any request is still pending
//   err                 - sticky watchdog-timeout flag
module mem_arbiter #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    ctrl_bus_if.central       ctrl_bus,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall,
    output logic              err
);

    localparam int unsigned WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t            state_q;
    logic              owner_d_q;   // 1: data port owns the current transaction
    logic              last_d_q;    // 1: data port was granted most recently
    logic [WD_W-1:0]   wdog_q;
    logic              pick_d;
    logic              abort;
    logic              finish;

    // Data wins if it is the only requester, or if both request and fetch
    // was the last one served.
    assign pick_d = d_req & (~i_req | ~last_d_q);

    // An ack in the same cycle the watchdog expires takes priority.
    assign abort  = ~m_ack & (wdog_q == WD_LIMIT);
    assign finish = m_ack | abort;

    assign stall  = (i_req & ~i_ready) | (d_req & ~d_ready);

    always_ff @(posedge ctrl_bus.clk) begin
        if (ctrl_bus.reset) begin
            state_q   <= IDLE;
            owner_d_q <= 1'b0;
            last_d_q  <= 1'b1;
            wdog_q    <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_req | d_req) begin
                        m_req     <= 1'b1;
                        m_we      <= pick_d & d_we;
                        m_addr    <= pick_d ? d_addr : i_addr;
                        if (pick_d) begin
                            m_wdata <= d_wdata;
                        end
                        owner_d_q <= pick_d;
                        last_d_q  <= pick_d;
                        wdog_q    <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        m_req   <= 1'b0;
                        state_q <= RESP;
                        if (abort) begin
                            err <= 1'b1;
                        end
                        if (owner_d_q) begin
                            d_ready <= 1'b1;
                            // Stores leave the load-data register untouched.
                            if (!m_we) begin
                                d_rdata <= m_ack ? m_rdata : ERR_DATA;
                            end
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= m_ack ? m_rdata : ERR_DATA;
                        end
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with fixed expected
// values, then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned TMO   = 4;
    localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;
    localparam int unsigned NEVER = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    ctrl_bus_if bus (.clk(clk));

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          stall;
    logic          err;

    mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO),
        .ERR_DATA(ERRD)
    ) dut (
        .ctrl_bus(bus),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .stall   (stall),
        .err     (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] refmem  [8];
    logic [31:0] fakemem [8];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_ack   = 1'b0;
        m_rdata = '0;
        bus.reset = 1'b1;
        tick();
        tick();
        bus.reset = 1'b0;
    endtask

    // Transaction-level model: one grant at a time, round-robin on ties,
    // ready at grant + 2 + min(wait, TIMEOUT) cycles, sticky error on timeout.
    task automatic random_phase(input int unsigned ncyc);
        bit          i_pend = 0, d_pend = 0, dw = 0;
        int unsigned i_gap = 0, d_gap = 0;
        logic [31:0] ia = '0, da = '0, dwd = '0;
        bit          busy = 0, cur_d = 0, cur_to = 0, m_last_d = 1, e_err = 0, c_we = 0;
        int unsigned cur_start = 0, cur_ready = 0, cur_wait = 0;
        logic [31:0] c_addr = '0, c_wd = '0, e_ird = '0, e_drd = '0;
        bit          e_ir, e_dr, in_win;
        for (int unsigned c = 0; c < ncyc; c++) begin
            in_win = busy && c >= cur_start && c < cur_ready;
            e_ir   = busy && c == cur_ready && !cur_d;
            e_dr   = busy && c == cur_ready && cur_d;
            check_val("rnd_m_req",   32'(m_req),   32'(in_win));
            check_val("rnd_i_ready", 32'(i_ready), 32'(e_ir));
            check_val("rnd_d_ready", 32'(d_ready), 32'(e_dr));
            if (busy && c == cur_start) begin
                check_val("rnd_m_addr", m_addr,     c_addr);
                check_val("rnd_m_we",   32'(m_we),  32'(c_we));
                if (c_we) check_val("rnd_m_wdata", m_wdata, c_wd);
            end
            if (busy && c == cur_ready) begin
                if (cur_to) e_err = 1;
                if (!c_we) begin
                    if (cur_d) e_drd = cur_to ? ERRD : refmem[c_addr[4:2]];
                    else       e_ird = cur_to ? ERRD : refmem[c_addr[4:2]];
                end else if (!cur_to) begin
                    refmem[c_addr[4:2]] = c_wd;
                end
                check_val("rnd_i_rdata", i_rdata,  e_ird);
                check_val("rnd_d_rdata", d_rdata,  e_drd);
                check_val("rnd_err",     32'(err), 32'(e_err));
            end

            // Backing memory: acks after the chosen wait, stray acks otherwise.
            m_ack   = 1'b0;
            m_rdata = $urandom;
            if (in_win) begin
                if (cur_wait != NEVER && c == cur_start + cur_wait) begin
                    m_ack = 1'b1;
                    if (m_we) fakemem[m_addr[4:2]] = m_wdata;
                    else      m_rdata = fakemem[m_addr[4:2]];
                end
            end else if ($urandom_range(0, 4) == 0) begin
                m_ack = 1'b1;
            end

            // Requesters: drop the cycle after ready, then maybe idle a while.
            if (busy && c == cur_ready + 1) begin
                if (cur_d) begin d_pend = 0; d_gap = $urandom_range(0, 2); end
                else       begin i_pend = 0; i_gap = $urandom_range(0, 2); end
            end
            if (!i_pend) begin
                if (i_gap == 0) begin
                    i_pend = 1;
                    ia = ($urandom & 32'hFFFF_FFE3) | (32'($urandom_range(0, 7)) << 2);
                end else i_gap--;
            end
            if (!d_pend) begin
                if (d_gap == 0) begin
                    d_pend = 1;
                    da  = ($urandom & 32'hFFFF_FFE3) | (32'($urandom_range(0, 7)) << 2);
                    dw  = 1'($urandom_range(0, 1));
                    dwd = $urandom;
                end else d_gap--;
            end

            if ((!busy || c > cur_ready) && (i_pend || d_pend)) begin
                cur_d     = d_pend && (!i_pend || !m_last_d);
                m_last_d  = cur_d;
                busy      = 1;
                cur_start = c + 1;
                cur_wait  = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, TMO);
                cur_to    = (cur_wait == NEVER);
                cur_ready = cur_start + 1 + (cur_to ? TMO : cur_wait);
                c_addr    = cur_d ? da : ia;
                c_we      = cur_d ? dw : 1'b0;
                c_wd      = dwd;
            end

            i_req   = i_pend;
            i_addr  = ia;
            d_req   = d_pend;
            d_we    = dw;
            d_addr  = da;
            d_wdata = dwd;
            #1;
            check_val("rnd_stall", 32'(stall), 32'((i_pend & ~e_ir) | (d_pend & ~e_dr)));
            tick();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        m_ack = 1'b0;
    endtask

    initial begin
        bus.reset = 1'b0;

        // Reset state
        do_reset();
        check_val("rst_m_req",   32'(m_req),   32'd0);
        check_val("rst_m_we",    32'(m_we),    32'd0);
        check_val("rst_m_addr",  m_addr,       32'd0);
        check_val("rst_m_wdata", m_wdata,      32'd0);
        check_val("rst_i_ready", 32'(i_ready), 32'd0);
        check_val("rst_d_ready", 32'(d_ready), 32'd0);
        check_val("rst_i_rdata", i_rdata,      32'd0);
        check_val("rst_d_rdata", d_rdata,      32'd0);
        check_val("rst_err",     32'(err),     32'd0);
        check_val("rst_stall",   32'(stall),   32'd0);

        // Single zero-wait fetch
        i_req = 1'b1; i_addr = 32'h0000_0040; #1;
        check_val("t1_stall_c0", 32'(stall), 32'd1);
        tick();
        check_val("t1_m_req_c1",  32'(m_req), 32'd1);
        check_val("t1_m_addr_c1", m_addr,     32'h40);
        check_val("t1_m_we_c1",   32'(m_we),  32'd0);
        check_val("t1_stall_c1",  32'(stall), 32'd1);
        m_ack = 1'b1; m_rdata = 32'h2008_0005;
        tick();
        m_ack = 1'b0;
        check_val("t1_i_ready_c2", 32'(i_ready), 32'd1);
        check_val("t1_i_rdata_c2", i_rdata,      32'h2008_0005);
        check_val("t1_m_req_c2",   32'(m_req),   32'd0);
        check_val("t1_stall_c2",   32'(stall),   32'd0);
        tick();
        check_val("t1_i_ready_c3", 32'(i_ready), 32'd0);
        i_req = 1'b0;

        // Simultaneous requests after reset: fetch, data, fetch
        do_reset();
        i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        tick();
        check_val("t2_first_addr", m_addr, 32'h44);
        m_ack = 1'b1; m_rdata = 32'hAAAA_0001;
        tick();
        m_ack = 1'b0;
        check_val("t2_i_ready_c2", 32'(i_ready), 32'd1);
        check_val("t2_d_ready_c2", 32'(d_ready), 32'd0);
        check_val("t2_stall_c2",   32'(stall),   32'd1);
        tick();
        i_addr = 32'h48;
        tick();
        check_val("t2_second_addr", m_addr, 32'h80);
        m_ack = 1'b1; m_rdata = 32'h1111_2222;
        tick();
        m_ack = 1'b0;
        check_val("t2_d_ready_c5", 32'(d_ready), 32'd1);
        check_val("t2_d_rdata_c5", d_rdata,      32'h1111_2222);
        check_val("t2_i_ready_c5", 32'(i_ready), 32'd0);
        tick();
        d_addr = 32'h84;
        tick();
        check_val("t2_third_addr", m_addr, 32'h48);
        m_ack = 1'b1; m_rdata = 32'hAAAA_0002;
        tick();
        m_ack = 1'b0;
        check_val("t2_i_ready_3rd", 32'(i_ready), 32'd1);
        tick();
        i_req = 1'b0;
        tick();
        m_ack = 1'b1; m_rdata = 32'h1111_3333;
        tick();
        m_ack = 1'b0;
        check_val("t2_d_rdata_4th", d_rdata, 32'h1111_3333);
        tick();
        d_req = 1'b0;

        // Store with 3 wait cycles
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("t3_m_we",    32'(m_we),  32'd1);
            check_val("t3_m_wdata", m_wdata,    32'hCAFE_F00D);
            check_val("t3_m_req",   32'(m_req), 32'd1);
            check_val("t3_d_ready", 32'(d_ready), 32'd0);
            if (k == 3) begin m_ack = 1'b1; m_rdata = 32'h5A5A_5A5A; end
        end
        tick();
        m_ack = 1'b0;
        check_val("t3_d_ready", 32'(d_ready), 32'd1);
        check_val("t3_d_rdata", d_rdata,      32'h1111_3333);
        tick();
        d_req = 1'b0; d_we = 1'b0;

        // Watchdog timeout on a load
        d_req = 1'b1; d_addr = 32'h200;
        for (int k = 0; k <= int'(TMO); k++) begin
            tick();
            check_val("t4_m_req_hold", 32'(m_req),   32'd1);
            check_val("t4_no_ready",   32'(d_ready), 32'd0);
        end
        tick();
        check_val("t4_m_req_drop", 32'(m_req),   32'd0);
        check_val("t4_d_ready",    32'(d_ready), 32'd1);
        check_val("t4_d_rdata",    d_rdata,      ERRD);
        check_val("t4_err",        32'(err),     32'd1);
        tick();
        d_req = 1'b0;
        i_req = 1'b1; i_addr = 32'h500;
        tick();
        m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
        tick();
        m_ack = 1'b0;
        check_val("t4_good_rdata", i_rdata,  32'h0BAD_F00D);
        check_val("t4_err_sticky", 32'(err), 32'd1);
        tick();
        i_req = 1'b0;

        // Reset during the second wait cycle of a fetch
        i_req = 1'b1; i_addr = 32'h300;
        tick();
        tick();
        bus.reset = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
        tick();
        bus.reset = 1'b0;
        check_val("t5_m_req",   32'(m_req),   32'd0);
        check_val("t5_i_ready", 32'(i_ready), 32'd0);
        check_val("t5_d_ready", 32'(d_ready), 32'd0);
        check_val("t5_err",     32'(err),     32'd0);
        tick();
        check_val("t5_grant_addr", m_addr,       32'h300);
        check_val("t5_grant_we",   32'(m_we),    32'd0);
        check_val("t5_no_ready",   32'(i_ready), 32'd0);
        m_ack = 1'b1; m_rdata = 32'h3030_3030;
        tick();
        m_ack = 1'b0;
        check_val("t5_i_ready", 32'(i_ready), 32'd1);
        check_val("t5_i_rdata", i_rdata,      32'h3030_3030);
        tick();
        i_req = 1'b0;
        tick();
        check_val("t5_d_addr", m_addr, 32'h304);
        m_ack = 1'b1; m_rdata = 32'h3434_3434;
        tick();
        m_ack = 1'b0;
        check_val("t5_d_rdata", d_rdata, 32'h3434_3434);
        tick();
        d_req = 1'b0;

        // Stray acks in IDLE and RESP
        m_ack = 1'b1; m_rdata = 32'h5555_AAAA;
        tick();
        m_ack = 1'b0;
        check_val("t6_idle_m_req",   32'(m_req),   32'd0);
        check_val("t6_idle_i_ready", 32'(i_ready), 32'd0);
        check_val("t6_idle_d_ready", 32'(d_ready), 32'd0);
        check_val("t6_idle_i_rdata", i_rdata,      32'h3030_3030);
        check_val("t6_idle_d_rdata", d_rdata,      32'h3434_3434);
        i_req = 1'b1; i_addr = 32'h400;
        tick();
        m_ack = 1'b1; m_rdata = 32'h7777_0001;
        tick();
        m_rdata = 32'h9999_9999;
        tick();
        m_ack = 1'b0;
        i_req = 1'b0;
        check_val("t6_resp_i_ready", 32'(i_ready), 32'd0);
        check_val("t6_resp_m_req",   32'(m_req),   32'd0);
        check_val("t6_resp_i_rdata", i_rdata,      32'h7777_0001);
        check_val("t6_resp_d_rdata", d_rdata,      32'h3434_3434);
        tick();
        check_val("t6_after_m_req",  32'(m_req),   32'd0);

        // Randomized traffic
        for (int k = 0; k < 8; k++) begin
            refmem[k]  = $urandom;
            fakemem[k] = refmem[k];
        end
        do_reset();
        random_phase(800);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
